// File: rtl/multi_debouncer_if.sv
// Button bundle between the raw front-panel inputs and the debouncer.
// The master side drives the raw pushbutton levels; the slave side (the
// debouncer) returns the cleaned levels, edge pulses and the sample strobe.
interface multi_debouncer_if #(
    parameter int CHANNELS = 4
);
    logic [CHANNELS-1:0] pb_in;
    logic [CHANNELS-1:0] pb_level;
    logic [CHANNELS-1:0] pb_rise;
    logic [CHANNELS-1:0] pb_fall;
    logic [CHANNELS-1:0] pb_long;
    logic                tick;

    modport master (
        output pb_in,
        input  pb_level,
        input  pb_rise,
        input  pb_fall,
        input  pb_long,
        input  tick
    );

    modport slave (
        input  pb_in,
        output pb_level,
        output pb_rise,
        output pb_fall,
        output pb_long,
        output tick
    );
endinterface

// File: rtl/multi_debouncer.sv
// Multi-channel pushbutton debouncer.
// Each raw input is brought into the clk domain by a two-flop synchroniser,
// sampled on a shared prescaled tick and only accepted as a new level after
// STABLE_SAMPLES consecutive differing samples. Per channel it produces the
// clean level, one-clock press/release pulses and a one-shot long-press
// pulse after LONG_SAMPLES ticks of continuous press.
module multi_debouncer #(
    parameter int CHANNELS       = 4,
    parameter int CLK_FREQ       = 50_000_000,
    parameter int SAMPLE_FREQ    = 1_000,
    parameter int STABLE_SAMPLES = 20,
    parameter int LONG_SAMPLES   = 1_000,
    parameter int ACTIVE_LOW_IN  = 0
) (
    input  logic             clk,
    input  logic             rst,
    multi_debouncer_if.slave bus
);

    localparam int TICK_DIV = CLK_FREQ / SAMPLE_FREQ;
    localparam int PRESC_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int STAB_W   = (STABLE_SAMPLES > 0) ? $clog2(STABLE_SAMPLES + 1) : 1;
    localparam int LONG_W   = $clog2(LONG_SAMPLES + 1);

    localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(TICK_DIV - 1);
    localparam logic [PRESC_W-1:0] PRESC_PRE  = PRESC_W'(TICK_DIV - 2);
    localparam logic [PRESC_W-1:0] PRESC_ONE  = PRESC_W'(1);
    localparam logic [STAB_W-1:0]  STAB_LAST  = STAB_W'(STABLE_SAMPLES - 1);
    localparam logic [STAB_W-1:0]  STAB_ONE   = STAB_W'(1);
    localparam logic [LONG_W-1:0]  LONG_MAX   = LONG_W'(LONG_SAMPLES);
    localparam logic [LONG_W-1:0]  LONG_PRE   = LONG_W'(LONG_SAMPLES - 1);
    localparam logic [LONG_W-1:0]  LONG_ONE   = LONG_W'(1);

    // Inversion mask so that a sample of 1 always means "pressed".
    localparam logic [CHANNELS-1:0] INV_MASK =
        (ACTIVE_LOW_IN != 0) ? {CHANNELS{1'b1}} : {CHANNELS{1'b0}};

    // Prescaler and sample strobe
    logic [PRESC_W-1:0]  presc_r;
    logic                tick_r;

    // Synchroniser and normalised sample
    logic [CHANNELS-1:0] sync1_r;
    logic [CHANNELS-1:0] sync2_r;
    logic [CHANNELS-1:0] sample_s;

    // Per-channel debounce state and pulses
    logic [CHANNELS-1:0] level_r;
    logic [CHANNELS-1:0] level_s;
    logic [CHANNELS-1:0] rise_r;
    logic [CHANNELS-1:0] rise_s;
    logic [CHANNELS-1:0] fall_r;
    logic [CHANNELS-1:0] fall_s;
    logic [CHANNELS-1:0] long_r;
    logic [CHANNELS-1:0] long_s;
    logic [STAB_W-1:0]   stab_r [CHANNELS];
    logic [STAB_W-1:0]   stab_s [CHANNELS];
    logic [LONG_W-1:0]   hold_r [CHANNELS];
    logic [LONG_W-1:0]   hold_s [CHANNELS];

    // Free-running prescaler; tick is registered one count early so that it
    // is high exactly in the cycle where the counter sits on its last value.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            presc_r <= '0;
            tick_r  <= 1'b0;
        end else begin
            if (presc_r == PRESC_LAST) begin
                presc_r <= '0;
            end else begin
                presc_r <= presc_r + PRESC_ONE;
            end
            tick_r <= (presc_r == PRESC_PRE);
        end
    end

    // Two-flop synchroniser for every raw button input.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_r <= '0;
            sync2_r <= '0;
        end else begin
            sync1_r <= bus.pb_in;
            sync2_r <= sync1_r;
        end
    end

    assign sample_s = sync2_r ^ INV_MASK;

    // Next-state logic: stability run length, level acceptance, edge pulses
    // and the saturating long-press counter, evaluated per channel.
    always_comb begin
        level_s = level_r;
        rise_s  = '0;
        fall_s  = '0;
        long_s  = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            stab_s[i] = stab_r[i];
            hold_s[i] = hold_r[i];

            // A sample equal to the current level restarts the run; the
            // STABLE_SAMPLES-th differing sample in a row flips the level.
            if (tick_r) begin
                if (sample_s[i] == level_r[i]) begin
                    stab_s[i] = '0;
                end else if (stab_r[i] == STAB_LAST) begin
                    stab_s[i]  = '0;
                    level_s[i] = ~level_r[i];
                    rise_s[i]  = ~level_r[i];
                    fall_s[i]  = level_r[i];
                end else begin
                    stab_s[i] = stab_r[i] + STAB_ONE;
                end
            end else begin
                stab_s[i] = stab_r[i];
            end

            // Long-press time only accrues while the level is already high;
            // a release in this tick wins over a long-press firing, so the
            // pulses on one channel stay mutually exclusive.
            if (!level_r[i] || fall_s[i]) begin
                hold_s[i] = '0;
            end else if (tick_r && (hold_r[i] != LONG_MAX)) begin
                hold_s[i] = hold_r[i] + LONG_ONE;
                long_s[i] = (hold_r[i] == LONG_PRE);
            end else begin
                hold_s[i] = hold_r[i];
            end
        end
    end

    // Debounce state and registered output pulses.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            level_r <= '0;
            rise_r  <= '0;
            fall_r  <= '0;
            long_r  <= '0;
            for (int i = 0; i < CHANNELS; i++) begin
                stab_r[i] <= '0;
                hold_r[i] <= '0;
            end
        end else begin
            level_r <= level_s;
            rise_r  <= rise_s;
            fall_r  <= fall_s;
            long_r  <= long_s;
            for (int i = 0; i < CHANNELS; i++) begin
                stab_r[i] <= stab_s[i];
                hold_r[i] <= hold_s[i];
            end
        end
    end

    assign bus.pb_level = level_r;
    assign bus.pb_rise  = rise_r;
    assign bus.pb_fall  = fall_r;
    assign bus.pb_long  = long_r;
    assign bus.tick     = tick_r;

endmodule

// File: doc/multi_debouncer.md
Name: multi_debouncer

Overview:
- Parametrised, multi-channel successor to the single-button debouncer for the UART/control front panel.
- Each channel is synchronised to `clk`, sampled on a shared prescaled tick, and accepted only after a configurable run of identical samples.
- Per channel it outputs a clean level, one-clock press and release pulses, and a one-shot long-press pulse.
- Sits between the raw board pushbuttons/switches and the control FSMs.

Parameters:
- CHANNELS, 4, number of independent inputs.
- CLK_FREQ, 50_000_000, `clk` frequency in Hz.
- SAMPLE_FREQ, 1_000, sample tick rate in Hz; TICK_DIV = CLK_FREQ/SAMPLE_FREQ, and TICK_DIV must be at least 2.
- STABLE_SAMPLES, 20, consecutive differing samples required to change level; must be at least 1.
- LONG_SAMPLES, 1_000, ticks the level must stay high before `pb_long` fires; must be greater than STABLE_SAMPLES.
- ACTIVE_LOW_IN, 0, when 1, inputs are inverted after synchronisation so that 1 always means pressed.

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous, active-low reset (0 = reset).
- pb_in  input  CHANNELS  raw asynchronous button inputs.
- pb_level  output  CHANNELS  debounced level, 1 = pressed.
- pb_rise  output  CHANNELS  one-clk pulse when pb_level goes 0→1.
- pb_fall  output  CHANNELS  one-clk pulse when pb_level goes 1→0.
- pb_long  output  CHANNELS  one-clk pulse, at most once per press.
- tick  output  1  sample strobe, exported for debug/reuse.

Behaviour:
- **Reset.** While rst=0, all registers clear asynchronously: prescaler, sync flops, counters, pb_level, pb_rise, pb_fall, pb_long and tick all read 0.
  - After rst is released, no pulse is produced until a new qualified transition occurs, even if pb_in is held high.
- **Synchroniser.** Two flops per channel on `clk`; sample s = sync2 XOR ACTIVE_LOW_IN.
- **Prescaler.**
  - Counter runs 0..TICK_DIV-1 and wraps to 0.
  - tick is high for exactly one clk, in the cycle where count == TICK_DIV-1.
  - Counter width is $clog2(TICK_DIV).
- **Stability counter (per channel).** Updated only in tick cycles; width $clog2(STABLE_SAMPLES+1).
  - If s == pb_level: counter ← 0.
  - If s != pb_level and counter < STABLE_SAMPLES-1: counter increments.
  - If s != pb_level and counter == STABLE_SAMPLES-1: pb_level toggles, counter ← 0, and pb_rise or pb_fall is asserted on the same clock edge.
  - Net effect: a change is accepted at the STABLE_SAMPLES-th consecutive tick whose sample differs from pb_level.
  - Any intervening equal sample restarts the count. Glitches shorter than STABLE_SAMPLES-1 tick periods never propagate.
- **Pulses.** pb_rise, pb_fall and pb_long are registered, high for exactly one clk, then cleared. They never overlap on the same channel.
- **Latency.** From a clean input change to the pb_level edge: 2 clk (sync) plus between (STABLE_SAMPLES-1)·TICK_DIV and STABLE_SAMPLES·TICK_DIV clk, plus 1 clk.
- **Long-press counter (per channel).**
  - Width $clog2(LONG_SAMPLES+1).
  - Cleared while pb_level=0, and in the cycle pb_level rises.
  - While pb_level=1, increments on each tick up to LONG_SAMPLES and then saturates.
  - pb_long pulses on the tick where the count reaches LONG_SAMPLES; no repeat while held.
  - Release clears the counter. A release before LONG_SAMPLES produces pb_fall only.
- **Channels.** Fully independent. Simultaneous events on different channels in the same cycle each produce their own pulse.
- **Mid-operation reset.** Asserting rst mid-count discards all partial counts. A press still held at release requires a full STABLE_SAMPLES qualification before pb_level rises.

Test Plan:
Bench parameters: CLK_FREQ=1000, SAMPLE_FREQ=100 (TICK_DIV=10), STABLE_SAMPLES=4, LONG_SAMPLES=20, CHANNELS=4.
1. Hold rst=0 for 25 clk with pb_in=4'b1111 → all outputs 0 throughout; after release, tick first pulses at clk 10 and every 10 clk after.
2. pb_in[0] 0→1 and held → pb_level[0] rises 33–43 clk later; pb_rise[0] is high exactly 1 clk; channels 1–3 stay 0.
3. pb_in[1] toggles every 7 clk for 120 clk, then held at 1 → exactly one pb_rise[1]; pb_level[1] never returns to 0.
4. Channel 2 stable high, then pb_in[2]=0 for 25 clk (≤3 ticks) and back to 1 → no pb_fall[2]; pb_level[2] stays 1.
5. Channel 0 held 250 clk after pb_level rises → one pb_long[0] at the 20th tick after the rise, no repeat; release → one pb_fall[0]. Repeat with a 100 clk hold → pb_fall only, no pb_long.
6. Press ch3 and release ch2 in the same cycle → pb_rise[3] and pb_fall[2] in the same clk. Then pulse rst=0 for 3 clk during a new qualification on ch1 → counts discarded; ch1 needs a full 4 ticks after rst=1.
